flash_prefetch_buf: RTL and testbench
=====================================

Name: flash_prefetch_buf

Overview:
Wishbone read-line buffer between the CPU instruction/data bus and the byte-serial flash controller. A flash word read costs about 14 cycles, so the block holds one aligned line of LINE_WORDS words. Hits are served in one cycle. On a miss the block refills the whole line as sequential single-word Wishbone reads on its master port, which feeds the flash controller's slave port. Flash is read-only, so writes are acknowledged and discarded.

Parameters:
LINE_WORDS, 4, words per line; power of 2, range 2..16
IDX_W, 2, log2(LINE_WORDS); must be kept consistent with LINE_WORDS

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  reset, asynchronous, active-high
s_cyc_i  in  1  slave bus cycle
s_stb_i  in  1  slave strobe
s_we_i  in  1  slave write enable
s_sel_i  in  4  byte select; ignored, full word always returned
s_adr_i  in  32  byte address; bits [1:0] ignored
s_dat_i  in  32  write data; ignored
s_dat_o  out  32  read data
s_ack_o  out  1  slave acknowledge, one-cycle pulse
m_cyc_o  out  1  master cycle to flash controller
m_stb_o  out  1  master strobe
m_we_o  out  1  constant 0
m_sel_o  out  4  constant 4'hF
m_adr_o  out  32  word-aligned read address
m_dat_o  out  32  constant 0
m_dat_i  in  32  read data from flash controller
m_ack_i  in  1  flash controller acknowledge
inv_i  in  1  invalidate line, level-sampled each cycle

Behaviour:
- Async reset values: state=IDLE, valid=0, tag=0, cnt=0, inv_pend=0, s_ack_o=0, s_dat_o=0, m_cyc_o=0, m_stb_o=0, m_adr_o=0. Line storage is not reset.
- Tag is adr[31:IDX_W+2]. Word index is adr[IDX_W+1:2]. hit = valid & (tag == s_adr_i tag).
- State IDLE, request present (s_cyc_i & s_stb_i), sampled at an edge:
  - On write: go to ACK; s_dat_o=0; buffer unchanged; no master activity.
  - On read hit: go to ACK; s_dat_o = line[index].
  - On read miss: latch req_adr = s_adr_i; set valid=0, cnt=0; go to REQ.
- State REQ: m_cyc_o=m_stb_o=1 and m_adr_o = {req tag, cnt, 2'b00}. Hold until m_ack_i is sampled high. Then write line[cnt] = m_dat_i, drop m_cyc_o/m_stb_o at that same edge, and go to GAP.
  - The mandatory drop after ack lets the flash controller reset its wait counter; it keeps ack high until cyc/stb fall.
- State GAP: one cycle with the master idle.
  - If cnt != LINE_WORDS-1: cnt += 1, go to REQ.
  - Otherwise: tag = req tag, valid = !inv_pend, inv_pend=0, s_dat_o = line[req index] (include the just-written word), then go to ACK.
- State ACK: s_ack_o=1 for exactly one cycle, then IDLE.
  - At the end of a fill, if the slave has already dropped s_stb_i, the ack is still pulsed. The master must ignore it; the line remains usable.
- Hit latency: ack is high in the cycle after the request edge.
- Miss latency: LINE_WORDS × (flash word latency + 2) + 1 cycles.
- inv_i: in IDLE or ACK it clears valid at the next edge. In REQ/GAP it sets inv_pend, so the completing fill still returns data but is not marked valid. inv_i together with a request in IDLE: treat as a miss.
- Addresses ≥ 4 MB are forwarded unchanged; the flash controller uses adr[21:2].
- A slave request arriving during REQ/GAP is not sampled until IDLE. The slave holds stb and address stable until ack (classic Wishbone).
- Reset asserted mid-fill: outputs return to reset values immediately and the line is invalid. The downstream controller sees cyc drop and aborts.

Test Plan:
- Reset: assert wb_rst_i mid-cycle -> all outputs 0 asynchronously; after release a read of 0x0 misses.
- Cold miss: read 0x00000014, flash model returns adr+0xA0000000 after 14 cycles -> master reads 0x10, 0x14, 0x18, 0x1C in order, each followed by a one-cycle cyc low; slave gets s_dat_o=0xA0000014 with a single ack pulse.
- Hit: then read 0x0000001C -> ack in the next cycle, data 0xA000001C, master lines stay 0.
- Eviction: read 0x00000020 -> refill of 0x20..0x2C; then read 0x10 -> miss again.
- Write: write 0x10 with data 0xDEADBEEF -> one-cycle ack, no master cycle; next read 0x10 returns the flash value.
- Invalidate: pulse inv_i during the 2nd word of a fill -> data still returned; repeat read of the same address refills (4 master reads).

Source files
------------

// File: rtl/flash_prefetch_buf.sv
// flash_prefetch_buf
//   Single-line read buffer sitting in front of the byte-serial flash
//   controller. A read that hits the buffered line is acknowledged in the
//   following cycle. A read that misses refills the whole aligned line with
//   sequential single-word reads on the master port, then returns the
//   requested word. Writes are acknowledged and discarded.
//
// Ports
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   s_*                     Wishbone slave (CPU side)
//   m_*                     Wishbone master (flash controller side)
//   inv_i                   line invalidate, sampled every cycle
module flash_prefetch_buf #(
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  input  logic        s_we_i,
  input  logic [3:0]  s_sel_i,
  input  logic [31:0] s_adr_i,
  input  logic [31:0] s_dat_i,
  output logic [31:0] s_dat_o,
  output logic        s_ack_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        inv_i
);

  localparam int TAG_W = 32 - IDX_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, GAP, ACK} state_t;

  state_t            state_reg, state_next;
  logic              valid_reg, valid_next;
  logic [TAG_W-1:0]  tag_reg, tag_next;
  logic [IDX_W-1:0]  cnt_reg, cnt_next;
  logic              inv_pend_reg, inv_pend_next;
  logic [31:2]       req_adr_reg, req_adr_next;
  logic              s_ack_next;
  logic              m_cyc_next;
  logic [31:0]       m_adr_next;

  // Line storage; no reset so it maps onto plain memory.
  logic [31:0]       line_mem [LINE_WORDS];
  logic              line_we;
  logic [IDX_W-1:0]  rd_idx;
  logic              load_dat;
  logic              clr_dat;

  logic              req;
  logic [TAG_W-1:0]  s_tag;
  logic [IDX_W-1:0]  s_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic              hit;

  // Byte lanes, write data and the byte offset carry no information for a
  // read-only full-word buffer.
  logic              unused_ok;
  assign unused_ok = ^{s_sel_i, s_dat_i, s_adr_i[1:0]};

  assign req     = s_cyc_i & s_stb_i;
  assign s_tag   = s_adr_i[31:IDX_W+2];
  assign s_idx   = s_adr_i[IDX_W+1:2];
  assign req_tag = req_adr_reg[31:IDX_W+2];
  assign req_idx = req_adr_reg[IDX_W+1:2];
  assign hit     = valid_reg & (tag_reg == s_tag);

  assign m_stb_o = m_cyc_o;
  assign m_we_o  = 1'b0;
  assign m_sel_o = 4'hF;
  assign m_dat_o = 32'h0;

  always_comb begin
    state_next    = state_reg;
    valid_next    = valid_reg;
    tag_next      = tag_reg;
    cnt_next      = cnt_reg;
    inv_pend_next = inv_pend_reg;
    req_adr_next  = req_adr_reg;
    s_ack_next    = 1'b0;
    m_cyc_next    = m_cyc_o;
    m_adr_next    = m_adr_o;
    line_we       = 1'b0;
    load_dat      = 1'b0;
    clr_dat       = 1'b0;
    rd_idx        = req_idx;

    unique case (state_reg)
      IDLE: begin
        if (inv_i) valid_next = 1'b0;
        if (req) begin
          if (s_we_i) begin
            state_next = ACK;
            s_ack_next = 1'b1;
            clr_dat    = 1'b1;
          end else if (hit && !inv_i) begin
            state_next = ACK;
            s_ack_next = 1'b1;
            load_dat   = 1'b1;
            rd_idx     = s_idx;
          end else begin
            // Line is invalid for the whole refill so a reset or abort can
            // never leave a half-written line marked usable.
            req_adr_next = s_adr_i[31:2];
            valid_next   = 1'b0;
            cnt_next     = '0;
            m_cyc_next   = 1'b1;
            m_adr_next   = {s_tag, {IDX_W{1'b0}}, 2'b00};
            state_next   = REQ;
          end
        end
      end

      REQ: begin
        if (inv_i) inv_pend_next = 1'b1;
        if (m_ack_i) begin
          // Drop the strobe on the ack edge: the flash controller holds ack
          // until it sees cyc/stb fall and restarts its wait counter then.
          line_we    = 1'b1;
          m_cyc_next = 1'b0;
          state_next = GAP;
        end
      end

      GAP: begin
        if (cnt_reg != LAST_IDX) begin
          if (inv_i) inv_pend_next = 1'b1;
          cnt_next   = cnt_reg + 1'b1;
          m_cyc_next = 1'b1;
          m_adr_next = {req_tag, cnt_next, 2'b00};
          state_next = REQ;
        end else begin
          // The last word was written at the previous edge, so the memory
          // read here already sees it.
          tag_next      = req_tag;
          valid_next    = !(inv_pend_reg | inv_i);
          inv_pend_next = 1'b0;
          load_dat      = 1'b1;
          s_ack_next    = 1'b1;
          state_next    = ACK;
        end
      end

      ACK: begin
        if (inv_i) valid_next = 1'b0;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg    <= IDLE;
      valid_reg    <= 1'b0;
      tag_reg      <= '0;
      cnt_reg      <= '0;
      inv_pend_reg <= 1'b0;
      req_adr_reg  <= '0;
      s_ack_o      <= 1'b0;
      s_dat_o      <= 32'h0;
      m_cyc_o      <= 1'b0;
      m_adr_o      <= 32'h0;
    end else begin
      state_reg    <= state_next;
      valid_reg    <= valid_next;
      tag_reg      <= tag_next;
      cnt_reg      <= cnt_next;
      inv_pend_reg <= inv_pend_next;
      req_adr_reg  <= req_adr_next;
      s_ack_o      <= s_ack_next;
      m_cyc_o      <= m_cyc_next;
      m_adr_o      <= m_adr_next;
      if (clr_dat)
        s_dat_o <= 32'h0;
      else if (load_dat)
        s_dat_o <= line_mem[rd_idx];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (line_we) line_mem[cnt_reg] <= m_dat_i;
  end

endmodule

// File: tb/tb_flash_prefetch_buf.sv
module tb_flash_prefetch_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_cyc = 1'b0, s_stb = 1'b0, s_we = 1'b0;
  logic [3:0]  s_sel = 4'hF;
  logic [31:0] s_adr = 32'h0, s_dat_w = 32'h0;
  logic [31:0] s_dat_r;
  logic        s_ack;
  logic        m_cyc, m_stb, m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_adr, m_dat_w, m_dat_r;
  logic        m_ack;
  logic        inv = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  flash_prefetch_buf #(.LINE_WORDS(4), .IDX_W(2)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_we_i(s_we), .s_sel_i(s_sel),
    .s_adr_i(s_adr), .s_dat_i(s_dat_w), .s_dat_o(s_dat_r), .s_ack_o(s_ack),
    .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_sel_o(m_sel),
    .m_adr_o(m_adr), .m_dat_o(m_dat_w), .m_dat_i(m_dat_r), .m_ack_i(m_ack),
    .inv_i(inv)
  );

  // Flash controller model: 14-cycle word latency, ack held until cyc/stb fall.
  int fcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) fcnt <= 0;
    else if (!(m_cyc && m_stb)) fcnt <= 0;
    else if (fcnt < 14) fcnt <= fcnt + 1;
  end
  assign m_ack   = m_cyc & m_stb & (fcnt == 14);
  assign m_dat_r = m_adr + 32'hA000_0000;

  // Master read log and check that cyc is low for the cycle after each ack.
  logic [31:0] mrd[$];
  int          gap_viol = 0;
  logic        acked = 1'b0;
  always @(posedge clk) begin
    acked <= 1'b0;
    if (m_cyc && m_stb && m_ack) begin
      mrd.push_back(m_adr);
      acked <= 1'b1;
    end
  end
  always @(negedge clk) if (acked && m_cyc) gap_viol++;

  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                     output logic [31:0] rdat, output int cyc_cnt, output bit ack2);
    @(negedge clk);
    s_cyc = 1'b1; s_stb = 1'b1; s_we = we; s_adr = adr; s_dat_w = wdat;
    cyc_cnt = 0;
    do begin
      @(negedge clk);
      cyc_cnt++;
    end while (!s_ack && cyc_cnt < 300);
    rdat = s_dat_r;
    if (!s_ack) begin
      vectors++; miscompares++;
      $display("FAIL timeout adr=%h: no ack within %0d cycles, required ack", adr, cyc_cnt);
    end
    @(posedge clk); #1;
    s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
    @(negedge clk);
    ack2 = s_ack;
    $display("txn %s adr=%h data=%h cycles=%0d mreads=%0d", we ? "WR" : "RD", adr, rdat, cyc_cnt, mrd.size());
  endtask

  task automatic test_reset();
    logic [31:0] d; int c; bit a2;
    repeat (3) @(negedge clk);
    vectors++; if ({s_ack, m_cyc, m_stb} !== 3'b000) begin miscompares++;
      $display("FAIL reset_ctl got ack/cyc/stb=%b want 000", {s_ack, m_cyc, m_stb}); end
    vectors++; if (s_dat_r !== 32'h0 || m_adr !== 32'h0) begin miscompares++;
      $display("FAIL reset_data got s_dat=%h m_adr=%h want 0/0", s_dat_r, m_adr); end
    rst = 1'b0;
    // start a fill, then reset it in the middle of a clock cycle
    @(negedge clk);
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = 32'h14;
    repeat (20) @(negedge clk);
    vectors++; if (m_cyc !== 1'b1) begin miscompares++;
      $display("FAIL midfill_cyc got %b want 1", m_cyc); end
    #2 rst = 1'b1;
    #1;
    vectors++; if ({s_ack, m_cyc, m_stb} !== 3'b000 || m_adr !== 32'h0 || s_dat_r !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset got ack/cyc/stb=%b m_adr=%h s_dat=%h want 000/0/0",
               {s_ack, m_cyc, m_stb}, m_adr, s_dat_r); end
    s_cyc = 1'b0; s_stb = 1'b0;
    @(negedge clk); rst = 1'b0;
    mrd.delete();
    bus(1'b0, 32'h0, 32'h0, d, c, a2);
    vectors++; if (c !== 65) begin miscompares++;
      $display("FAIL post_reset_miss cycles got %0d want 65", c); end
    vectors++; if (d !== 32'hA000_0000) begin miscompares++;
      $display("FAIL post_reset_data got %h want a0000000", d); end
  endtask

  task automatic test_cold_miss();
    logic [31:0] d; int c; bit a2;
    logic [31:0] exp_adr [4] = '{32'h10, 32'h14, 32'h18, 32'h1C};
    mrd.delete(); gap_viol = 0;
    bus(1'b0, 32'h14, 32'h0, d, c, a2);
    vectors++; if (d !== 32'hA000_0014) begin miscompares++;
      $display("FAIL miss_data got %h want a0000014", d); end
    vectors++; if (c !== 65) begin miscompares++;
      $display("FAIL miss_latency got %0d want 65", c); end
    vectors++; if (a2 !== 1'b0) begin miscompares++;
      $display("FAIL miss_ack_pulse got second-cycle ack %b want 0", a2); end
    vectors++; if (mrd.size() !== 4) begin miscompares++;
      $display("FAIL miss_reads got %0d want 4", mrd.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < mrd.size()) begin
        vectors++; if (mrd[i] !== exp_adr[i]) begin miscompares++;
          $display("FAIL miss_adr%0d got %h want %h", i, mrd[i], exp_adr[i]); end
      end
    end
    vectors++; if (gap_viol !== 0) begin miscompares++;
      $display("FAIL miss_gap got %0d acks without cyc drop want 0", gap_viol); end
  endtask

  task automatic test_hit();
    logic [31:0] d; int c; bit a2;
    mrd.delete();
    bus(1'b0, 32'h1C, 32'h0, d, c, a2);
    vectors++; if (c !== 1) begin miscompares++;
      $display("FAIL hit_latency got %0d want 1", c); end
    vectors++; if (d !== 32'hA000_001C) begin miscompares++;
      $display("FAIL hit_data got %h want a000001c", d); end
    vectors++; if (mrd.size() !== 0 || m_cyc !== 1'b0) begin miscompares++;
      $display("FAIL hit_master got %0d reads cyc=%b want 0/0", mrd.size(), m_cyc); end
    vectors++; if (a2 !== 1'b0) begin miscompares++;
      $display("FAIL hit_ack_pulse got %b want 0", a2); end
  endtask

  task automatic test_eviction();
    logic [31:0] d; int c; bit a2;
    mrd.delete();
    bus(1'b0, 32'h20, 32'h0, d, c, a2);
    vectors++; if (d !== 32'hA000_0020) begin miscompares++;
      $display("FAIL evict_data got %h want a0000020", d); end
    vectors++; if (mrd.size() !== 4 || mrd[0] !== 32'h20 || mrd[3] !== 32'h2C) begin miscompares++;
      $display("FAIL evict_reads got n=%0d want 4 reads 20..2c", mrd.size()); end
    mrd.delete();
    bus(1'b0, 32'h10, 32'h0, d, c, a2);
    vectors++; if (c !== 65 || mrd.size() !== 4) begin miscompares++;
      $display("FAIL evict_remiss got cycles=%0d reads=%0d want 65/4", c, mrd.size()); end
  endtask

  task automatic test_write();
    logic [31:0] d; int c; bit a2;
    mrd.delete();
    bus(1'b1, 32'h10, 32'hDEAD_BEEF, d, c, a2);
    vectors++; if (c !== 1 || a2 !== 1'b0) begin miscompares++;
      $display("FAIL write_ack got latency=%0d second=%b want 1/0", c, a2); end
    vectors++; if (mrd.size() !== 0) begin miscompares++;
      $display("FAIL write_master got %0d reads want 0", mrd.size()); end
    vectors++; if (d !== 32'h0) begin miscompares++;
      $display("FAIL write_dat got %h want 0", d); end
    bus(1'b0, 32'h10, 32'h0, d, c, a2);
    vectors++; if (d !== 32'hA000_0010 || c !== 1) begin miscompares++;
      $display("FAIL write_readback got %h cycles=%0d want a0000010/1", d, c); end
  endtask

  task automatic test_invalidate();
    logic [31:0] d; int c; bit a2;
    mrd.delete();
    fork
      bus(1'b0, 32'h48, 32'h0, d, c, a2);
      begin
        for (int i = 0; i < 100 && mrd.size() < 1; i++) @(negedge clk);
        @(negedge clk);
        @(negedge clk); inv = 1'b1;
        @(negedge clk); inv = 1'b0;
      end
    join
    vectors++; if (d !== 32'hA000_0048 || c !== 65) begin miscompares++;
      $display("FAIL inv_fill got %h cycles=%0d want a0000048/65", d, c); end
    mrd.delete();
    bus(1'b0, 32'h48, 32'h0, d, c, a2);
    vectors++; if (mrd.size() !== 4 || d !== 32'hA000_0048) begin miscompares++;
      $display("FAIL inv_refill got reads=%0d data=%h want 4/a0000048", mrd.size(), d); end
    bus(1'b0, 32'h4C, 32'h0, d, c, a2);
    vectors++; if (c !== 1 || d !== 32'hA000_004C) begin miscompares++;
      $display("FAIL inv_then_hit got cycles=%0d data=%h want 1/a000004c", c, d); end
    @(negedge clk); inv = 1'b1;
    @(negedge clk); inv = 1'b0;
    mrd.delete();
    bus(1'b0, 32'h4C, 32'h0, d, c, a2);
    vectors++; if (c !== 65 || mrd.size() !== 4) begin miscompares++;
      $display("FAIL idle_inv got cycles=%0d reads=%0d want 65/4", c, mrd.size()); end
  endtask

  task automatic test_high_addr();
    logic [31:0] d; int c; bit a2;
    mrd.delete();
    bus(1'b0, 32'h1234_5678, 32'h0, d, c, a2);
    vectors++; if (d !== 32'hB234_5678) begin miscompares++;
      $display("FAIL high_data got %h want b2345678", d); end
    vectors++; if (mrd.size() !== 4 || mrd[0] !== 32'h1234_5670) begin miscompares++;
      $display("FAIL high_adr got n=%0d want 4 reads from 12345670", mrd.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_eviction();
    test_write();
    test_invalidate();
    test_high_addr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
